// File: rtl/load_store_unit_pkg.sv
// Shared types for the load/store unit: access size encoding and FSM states.
package load_store_unit_pkg;

  localparam int LSU_DATA_W = 32;

  // 2'b11 is not named; it is treated as a word access.
  typedef enum logic [1:0] {
    MEM_BYTE = 2'b00,
    MEM_HALF = 2'b01,
    MEM_WORD = 2'b10
  } mem_size_t;

  typedef enum logic {
    LSU_IDLE = 1'b0,
    LSU_RMW  = 1'b1
  } lsu_state_t;

endpackage

// File: rtl/load_store_unit_if.sv
// Pipeline-side and memory-side signals of the load/store unit.
// master = EX/MEM register plus data_memory, slave = load_store_unit.
interface load_store_unit_if #(
  parameter int DATA_W = 32
);
  import load_store_unit_pkg::*;

  logic [DATA_W-1:0] alu_out_m;
  logic [DATA_W-1:0] write_data_m;
  logic              mem_write_m;
  logic              mem_read_m;
  mem_size_t         mem_size_m;
  logic              mem_unsigned_m;
  logic [DATA_W-1:0] dm_read_data;
  logic [DATA_W-1:0] dm_addr;
  logic [DATA_W-1:0] dm_write_data;
  logic              dm_write_en;
  logic [DATA_W-1:0] read_data_m;
  logic              stall_m;
  logic              misalign_m;

  modport master (
    output alu_out_m, write_data_m, mem_write_m, mem_read_m, mem_size_m,
           mem_unsigned_m, dm_read_data,
    input  dm_addr, dm_write_data, dm_write_en, read_data_m, stall_m, misalign_m
  );

  modport slave (
    input  alu_out_m, write_data_m, mem_write_m, mem_read_m, mem_size_m,
           mem_unsigned_m, dm_read_data,
    output dm_addr, dm_write_data, dm_write_en, read_data_m, stall_m, misalign_m
  );
endinterface

// File: rtl/load_store_unit_lane_mux.sv
// Big-endian lane mux: extracts/extends a load from a memory word and
// merges sub-word store data into that word. Purely combinational.
module lsu_lane_mux
  import load_store_unit_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [DATA_W-1:0] word_i,
  input  logic [1:0]        off_i,
  input  mem_size_t         size_i,
  input  logic              unsigned_i,
  input  logic [DATA_W-1:0] wdata_i,
  output logic [DATA_W-1:0] load_o,
  output logic [DATA_W-1:0] merge_o
);
  localparam int NUM_LANES = DATA_W / 8;

  logic is_byte, is_half;
  assign is_byte = (size_i == MEM_BYTE);
  assign is_half = (size_i == MEM_HALF);

  // Store merge: byte lane 0 is the most significant byte of the word.
  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    localparam int         HI   = DATA_W - 1 - 8 * i;
    localparam logic [1:0] LANE = 2'(i);
    logic       sel;
    logic [7:0] src;
    assign sel = is_byte ? (off_i == LANE) :
                 is_half ? (off_i[1] == LANE[1]) : 1'b1;
    // Within a half, the even lane carries the upper store byte.
    assign src = is_byte ? wdata_i[7:0] :
                 is_half ? (LANE[0] ? wdata_i[7:0] : wdata_i[15:8]) : wdata_i[HI -: 8];
    assign merge_o[HI -: 8] = sel ? src : word_i[HI -: 8];
  end

  // Load extract and sign/zero extension.
  always_comb begin
    logic [7:0]  byte_v;
    logic [15:0] half_v;
    case (off_i)
      2'd0:    byte_v = word_i[31:24];
      2'd1:    byte_v = word_i[23:16];
      2'd2:    byte_v = word_i[15:8];
      default: byte_v = word_i[7:0];
    endcase
    half_v = off_i[1] ? word_i[15:0] : word_i[31:16];
    if (is_byte)
      load_o = {{(DATA_W-8){byte_v[7] & ~unsigned_i}}, byte_v};
    else if (is_half)
      load_o = {{(DATA_W-16){half_v[15] & ~unsigned_i}}, half_v};
    else
      load_o = word_i;
  end
endmodule

// File: rtl/load_store_unit.sv
// Memory-stage load/store unit. Loads are combinational; SB/SH run as a
// two-cycle read-modify-write that stalls the pipeline for one cycle.
// Optional feature: define LSU_MISALIGN_TRAP_EN to flag and suppress
// misaligned HALF/WORD accesses; otherwise low address bits are ignored.
module load_store_unit
  import load_store_unit_pkg::*;
#(
  parameter int DATA_W    = LSU_DATA_W,
  parameter int MEM_DEPTH = 1024
) (
  input logic                clk,
  input logic                rst,
  load_store_unit_if.slave   bus
);
  if (DATA_W != 32) begin : g_bad_width
    $error("load_store_unit supports DATA_W=32 only");
  end
  if (MEM_DEPTH < 1) begin : g_bad_depth
    $error("load_store_unit needs MEM_DEPTH >= 1");
  end

  lsu_state_t        state_q, state_d;
  logic [DATA_W-1:0] rmw_data_q, rmw_data_d;
  logic [DATA_W-1:0] load_val, merge_val;
  logic              misalign, is_sub;

  assign bus.dm_addr = {2'b00, bus.alu_out_m[DATA_W-1:2]};
  assign is_sub      = (bus.mem_size_m == MEM_BYTE) || (bus.mem_size_m == MEM_HALF);

`ifdef LSU_MISALIGN_TRAP_EN
  // Only accesses that would otherwise proceed can be misaligned; reset masks the flag.
  always_comb begin
    misalign = 1'b0;
    if (!rst && (bus.mem_read_m || bus.mem_write_m)) begin
      if (bus.mem_size_m == MEM_HALF)      misalign = bus.alu_out_m[0];
      else if (bus.mem_size_m != MEM_BYTE) misalign = |bus.alu_out_m[1:0];
    end
  end
`else
  assign misalign = 1'b0;
`endif
  assign bus.misalign_m = misalign;

  lsu_lane_mux #(.DATA_W(DATA_W)) u_lane_mux (
    .word_i     (bus.dm_read_data),
    .off_i      (bus.alu_out_m[1:0]),
    .size_i     (bus.mem_size_m),
    .unsigned_i (bus.mem_unsigned_m),
    .wdata_i    (bus.write_data_m),
    .load_o     (load_val),
    .merge_o    (merge_val)
  );

  // Loads return data only when no store shares the cycle.
  assign bus.read_data_m = (bus.mem_read_m && !bus.mem_write_m && !misalign) ? load_val : '0;

  // FSM next state and memory strobes; reset aborts any pending write.
  always_comb begin
    state_d           = state_q;
    rmw_data_d        = rmw_data_q;
    bus.stall_m       = 1'b0;
    bus.dm_write_en   = 1'b0;
    bus.dm_write_data = bus.write_data_m;
    case (state_q)
      LSU_IDLE: begin
        if (bus.mem_write_m && !misalign) begin
          if (is_sub) begin
            rmw_data_d  = merge_val;
            bus.stall_m = 1'b1;
            state_d     = LSU_RMW;
          end else begin
            bus.dm_write_en = 1'b1;
          end
        end
      end
      LSU_RMW: begin
        bus.dm_write_en   = 1'b1;
        bus.dm_write_data = rmw_data_q;
        state_d           = LSU_IDLE;
      end
      default: state_d = LSU_IDLE;
    endcase
    if (rst) begin
      state_d         = LSU_IDLE;
      rmw_data_d      = '0;
      bus.stall_m     = 1'b0;
      bus.dm_write_en = 1'b0;
    end
  end

  // State and merged-word registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= LSU_IDLE;
      rmw_data_q <= '0;
    end else begin
      state_q    <= state_d;
      rmw_data_q <= rmw_data_d;
    end
  end
endmodule
